dec_onehot2bin: RTL and testbench
=================================

// Module: dec_onehot2bin
// PURPOSE
//   Receive-side companion of the binary-to-one-hot encoder: converts a 15-bit one-hot word back to a 4-bit binary code.
//   Input and output use valid/ready handshakes, with a 2-entry output buffer so downstream backpressure never drops a word.
//   Sits on the decode side of the one-hot transport.
//   Flags malformed (multi-hot) words.
// PARAMETERS
//   N      15  one-hot input width; legal codes 0..N-1, all-zero word encodes code N
//   W       4  binary output width, $clog2(N+1)
//   CNT_W   8  error counter width (used only with ERR_CNT_EN)
// PORTS
//   clk        in   1      clock, all state updates on rising edge
//   rst        in   1      synchronous reset, active-low (0 = reset)
//   in_valid   in   1      input word present
//   in_ready   out  1      block can accept a word this cycle
//   in         in   N      one-hot word
//   out_valid  out  1      head-of-buffer entry valid
//   out_ready  in   1      downstream accepts head entry
//   out        out  W      decoded binary code of head entry
//   err        out  1      head entry came from a multi-hot word
//   err_cnt    out  CNT_W  saturating count of accepted multi-hot words (ERR_CNT_EN only)
// BEHAVIOUR
//   Reset (rst=0 at clk edge): occupancy=EMPTY; out_valid=0, out=0, err=0, err_cnt=0; in_ready=1 from the next cycle.
//     Reset mid-operation flushes both entries without emitting them.
//   Accept: push = in_valid & in_ready.
//   Deliver: pop = out_valid & out_ready.
//   Decode (combinational, captured on push):
//     exactly one bit k set -> code k, err=0
//     all bits zero         -> code N (4'hF), err=0; this is a legal encoding, not an error
//     two or more bits set  -> code = index of lowest set bit, err=1
//   Buffer: 2-entry FIFO, with occupancy FSM EMPTY/ONE/TWO.
//     EMPTY: push -> ONE
//     ONE:   push&!pop -> TWO; !push&pop -> EMPTY; push&pop -> ONE (new word becomes head next cycle)
//     TWO:   pop -> ONE; push impossible
//   Handshake signals:
//     in_ready = (occupancy != TWO); registered, no combinational path from out_ready
//     out_valid = (occupancy != EMPTY)
//     out/err are stable while out_valid=1 and out_ready=0
//   Latency: a word pushed at edge t appears on out at edge t (out_valid=1 in the following cycle) when EMPTY.
//   Throughput: 1 word/cycle sustained while out_ready=1.
//   Ordering: strict FIFO; entries are never reordered, duplicated or dropped.
//   in is ignored when in_valid=0, including X on in.
// CONFIGURATION
//   ERR_CNT_EN defined:
//     err_cnt increments by 1 on each push whose word is multi-hot.
//     err_cnt saturates at 2^CNT_W-1 and clears only on reset.
//   ERR_CNT_EN undefined: err_cnt port and counter logic are absent; all other behaviour is identical.
// TESTING
//   Reset: hold rst=0 for 2 cycles -> out_valid=0, out=0, err=0, err_cnt=0; in_ready=1 after release.
//   Sweep: push in=1<<k for k=0..14, then in=0, with out_ready=1 -> out=0..14 then 15 in order, err=0, 1-cycle latency.
//   Backpressure: out_ready=0, push 0x0008 then 0x0100 -> in_ready=0 in the third cycle;
//     out_ready=1 -> out=3 then out=8, nothing lost.
//   Multi-hot: push 0x0120 -> out=5, err=1; with ERR_CNT_EN err_cnt=1;
//     300 such words -> err_cnt=255 (saturated).
//   Simultaneous: occupancy ONE with push 0x4000 and pop in the same cycle -> occupancy stays ONE;
//     next head out=14.
//   Mid-op reset: occupancy TWO, assert rst=0 for 1 cycle -> out_valid=0 next cycle, in_ready=1;
//     flushed words are never emitted.

Source files
------------

// File: rtl/dec_onehot2bin.sv
// One-hot to binary decoder with valid/ready handshakes and a 2-entry output FIFO.
// Optional saturating multi-hot counter on err_cnt when ERR_CNT_EN is defined.
module dec_onehot2bin #(
  parameter int N = 15,
  parameter int W = 4
`ifdef ERR_CNT_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out,
`ifdef ERR_CNT_EN
  output logic [CNT_W-1:0] err_cnt,
`endif
  output logic             err
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;

  occ_e           state_q, state_d;
  logic           in_ready_q, out_valid_q;
  logic [W-1:0]   head_code_q, tail_code_q;
  logic           head_err_q, tail_err_q;
  logic [W-1:0]   dec_code;
  logic           dec_err;
  logic           push, pop;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  // Lowest set bit wins, so multi-hot words still yield a deterministic code.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    dec_code = W'(N);
    dec_err  = |(in & (in - N'(1)));
    for (int k = N - 1; k >= 0; k--) begin
      if (in[k]) dec_code = W'(k);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = TWO;
        else if (!push && pop) state_d = EMPTY;
      end
      TWO:     if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_code_q <= '0;
      head_err_q  <= 1'b0;
      tail_code_q <= '0;
      tail_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != EMPTY);
      if (state_q == TWO) begin
        if (pop) begin
          head_code_q <= tail_code_q;
          head_err_q  <= tail_err_q;
        end
      end else if (push) begin
        // New word goes straight to head when the head is free or leaving now.
        if (state_q == EMPTY || pop) begin
          head_code_q <= dec_code;
          head_err_q  <= dec_err;
        end else begin
          tail_code_q <= dec_code;
          tail_err_q  <= dec_err;
        end
      end
    end
  end

`ifdef ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt_q <= '0;
    end else if (push && dec_err && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = head_code_q;
  assign err       = head_err_q;

endmodule

// File: tb/tb_dec_onehot2bin.sv
// Directed self-checking bench for dec_onehot2bin; covers the err_cnt port when ERR_CNT_EN is defined.
module tb_dec_onehot2bin;

  localparam int N = 15;
  localparam int W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out;
  logic             err;
`ifdef ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dec_onehot2bin #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
`ifdef ERR_CNT_EN
    .err_cnt   (err_cnt),
`endif
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in = '0; out_ready = 1'b0;

    // Reset held for two cycles
    step(); step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_err", 32'(err), 32'd0);
`ifdef ERR_CNT_EN
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst = 1'b1;
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_idle_valid", 32'(out_valid), 32'd0);

    // Sweep: one-hot codes 0..14 then all-zero word as code 15
    out_ready = 1'b1;
    for (int k = 0; k <= N; k++) begin
      in_valid = 1'b1;
      in = (k < N) ? (N'(1) << k) : '0;
      step();
      check($sformatf("sweep_valid_%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("sweep_out_%0d", k), 32'(out), 32'(k));
      check($sformatf("sweep_err_%0d", k), 32'(err), 32'd0);
      check($sformatf("sweep_ready_%0d", k), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("sweep_drain", 32'(out_valid), 32'd0);

    // X on in while in_valid=0 must be ignored
    in = 'x;
    step();
    check("x_ignored_valid", 32'(out_valid), 32'd0);

    // Backpressure: fill both entries, extra word must be refused
    out_ready = 1'b0;
    in_valid = 1'b1; in = 15'h0008;
    step();
    check("bp_first_out", 32'(out), 32'd3);
    check("bp_first_ready", 32'(in_ready), 32'd1);
    in = 15'h0100;
    step();
    check("bp_full_ready", 32'(in_ready), 32'd0);
    check("bp_full_out", 32'(out), 32'd3);
    in = 15'h0002;
    step();
    check("bp_hold_out", 32'(out), 32'd3);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("bp_second_out", 32'(out), 32'd8);
    check("bp_second_valid", 32'(out_valid), 32'd1);
    check("bp_second_ready", 32'(in_ready), 32'd1);
    step();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Multi-hot words: lowest set bit, err=1
    in_valid = 1'b1; in = 15'h0120;
    step();
    check("mh_out", 32'(out), 32'd5);
    check("mh_err", 32'(err), 32'd1);
`ifdef ERR_CNT_EN
    check("mh_cnt1", 32'(err_cnt), 32'd1);
`endif
    in = 15'h7FFF;
    step();
    check("mh_all_out", 32'(out), 32'd0);
    check("mh_all_err", 32'(err), 32'd1);
    in = 15'h6000;
    step();
    check("mh_top_out", 32'(out), 32'd13);
    check("mh_top_err", 32'(err), 32'd1);
    in = 15'h0400;
    step();
    check("mh_clean_out", 32'(out), 32'd10);
    check("mh_clean_err", 32'(err), 32'd0);
`ifdef ERR_CNT_EN
    check("mh_cnt3", 32'(err_cnt), 32'd3);
    // 252 more multi-hot pushes reach 255, then 45 more stay saturated
    in = 15'h0120;
    for (int i = 0; i < 252; i++) step();
    check("cnt_at_max", 32'(err_cnt), 32'd255);
    for (int i = 0; i < 45; i++) step();
    check("cnt_saturated", 32'(err_cnt), 32'd255);
`endif
    in_valid = 1'b0;
    step();
    check("mh_drained", 32'(out_valid), 32'd0);

    // Simultaneous push and pop in ONE keeps ONE
    out_ready = 1'b0;
    in_valid = 1'b1; in = 15'h0010;
    step();
    check("sim_head", 32'(out), 32'd4);
    out_ready = 1'b1; in = 15'h4000;
    step();
    check("sim_new_head", 32'(out), 32'd14);
    check("sim_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    step();
    check("sim_one_only", 32'(out_valid), 32'd0);

    // Mid-operation reset flushes a full buffer
    out_ready = 1'b0;
    in_valid = 1'b1; in = 15'h0001;
    step();
    in = 15'h0002;
    step();
    check("mid_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0; rst = 1'b0;
    step();
    rst = 1'b1;
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_ready", 32'(in_ready), 32'd1);
    check("mid_out", 32'(out), 32'd0);
`ifdef ERR_CNT_EN
    check("mid_cnt", 32'(err_cnt), 32'd0);
`endif
    out_ready = 1'b1;
    step(); step();
    check("mid_no_emit", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
